// File: rtl/axi4l_pkg.sv
// rtl/axi4l_pkg.sv - AXI4-Lite shared types for the master bridge slice
// Purpose: address/data/strobe/response types and a response-error helper.
// Ports: none (package).
package axi4l_pkg;

   typedef logic [31:0] addr_t;
   typedef logic [31:0] data_t;
   typedef logic [3:0]  strb_t;

   typedef enum logic [1:0] {
      OKAY   = 2'b00,
      EXOKAY = 2'b01,
      SLVERR = 2'b10,
      DECERR = 2'b11
   } resp_t;

   function automatic logic resp_is_err(input resp_t resp);
      return resp != OKAY;
   endfunction

endpackage

// File: rtl/axi4l_if.sv
// rtl/axi4l_if.sv - AXI4-Lite channel bundle with master/slave modports
// Purpose: the five AXI4-Lite channels (AW, W, B, AR, R).
// Ports: master modport drives valids/payload and bready/rready;
//        slave modport drives readies and B/R responses.
interface axi4l_if;
   import axi4l_pkg::*;

   addr_t      awaddr;
   logic [2:0] awprot;
   logic       awvalid;
   logic       awready;

   data_t      wdata;
   strb_t      wstrb;
   logic       wvalid;
   logic       wready;

   resp_t      bresp;
   logic       bvalid;
   logic       bready;

   addr_t      araddr;
   logic [2:0] arprot;
   logic       arvalid;
   logic       arready;

   data_t      rdata;
   resp_t      rresp;
   logic       rvalid;
   logic       rready;

   modport master (
      output awaddr, awprot, awvalid, input awready,
      output wdata, wstrb, wvalid, input wready,
      input  bresp, bvalid, output bready,
      output araddr, arprot, arvalid, input arready,
      input  rdata, rresp, rvalid, output rready
   );

   modport slave (
      input  awaddr, awprot, awvalid, output awready,
      input  wdata, wstrb, wvalid, output wready,
      output bresp, bvalid, input bready,
      input  araddr, arprot, arvalid, output arready,
      output rdata, rresp, rvalid, input rready
   );

endinterface

// File: rtl/axi4l_master_bridge.sv
// rtl/axi4l_master_bridge.sv - single-outstanding core request to AXI4-Lite initiator
// Purpose: accepts one core request at a time and runs it as an AXI4-Lite
//          write (AW+W then B) or read (AR then R), returning a one-cycle
//          response strobe with error flag and read data.
// Ports:   aclk/aresetn (sync, active-low) | req_i/gnt_o/we_i/be_i/addr_i/wdata_i
//          core request | rvalid_o/rdata_o/err_o core response | axi master modport.
// Config:  AXI4L_MASTER_ALIGN_CHECK_EN - misaligned addresses complete locally
//          with err_o=1 and no AXI activity.
module axi4l_master_bridge
   import axi4l_pkg::*;
#(
   parameter logic [2:0] PROT = 3'b000
) (
   input  logic         aclk,
   input  logic         aresetn,
   input  logic         req_i,
   output logic         gnt_o,
   input  logic         we_i,
   input  logic [3:0]   be_i,
   input  logic [31:0]  addr_i,
   input  logic [31:0]  wdata_i,
   output logic         rvalid_o,
   output logic [31:0]  rdata_o,
   output logic         err_o,
   axi4l_if.master      axi
);

   typedef enum logic [2:0] {
      IDLE,
      WR_REQ,
      WR_RESP,
      RD_REQ,
      RD_RESP
`ifdef AXI4L_MASTER_ALIGN_CHECK_EN
      , ALIGN_ERR
`endif
   } state_t;

   state_t state;

   addr_t addr_q;
   data_t wdata_q;
   strb_t strb_q;
   logic  awvalid_q, wvalid_q, arvalid_q, bready_q, rready_q;
   logic  aw_done, w_done;
   logic  rvalid_q, err_q;
   data_t rdata_q;

   logic  aw_hs, w_hs, aw_fin, w_fin;

   assign aw_hs  = awvalid_q & axi.awready;
   assign w_hs   = wvalid_q & axi.wready;
   // A channel counts as finished if it completed earlier or completes now.
   assign aw_fin = aw_done | aw_hs;
   assign w_fin  = w_done | w_hs;

   assign gnt_o    = (state == IDLE);
   assign rvalid_o = rvalid_q;
   assign rdata_o  = rdata_q;
   assign err_o    = err_q;

   assign axi.awaddr  = addr_q;
   assign axi.awprot  = PROT;
   assign axi.awvalid = awvalid_q;
   assign axi.wdata   = wdata_q;
   assign axi.wstrb   = strb_q;
   assign axi.wvalid  = wvalid_q;
   assign axi.bready  = bready_q;
   assign axi.araddr  = addr_q;
   assign axi.arprot  = PROT;
   assign axi.arvalid = arvalid_q;
   assign axi.rready  = rready_q;

   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         state     <= IDLE;
         addr_q    <= '0;
         wdata_q   <= '0;
         strb_q    <= '0;
         awvalid_q <= 1'b0;
         wvalid_q  <= 1'b0;
         arvalid_q <= 1'b0;
         bready_q  <= 1'b0;
         rready_q  <= 1'b0;
         aw_done   <= 1'b0;
         w_done    <= 1'b0;
         rvalid_q  <= 1'b0;
         err_q     <= 1'b0;
         rdata_q   <= '0;
      end else begin
         rvalid_q <= 1'b0;
         case (state)
            IDLE: begin
               if (req_i) begin
                  addr_q <= addr_i;
                  // Reads keep write data and strobes at zero on the bus.
                  wdata_q <= we_i ? wdata_i : '0;
                  strb_q  <= we_i ? be_i : '0;
`ifdef AXI4L_MASTER_ALIGN_CHECK_EN
                  if (addr_i[1:0] != 2'b00) begin
                     state <= ALIGN_ERR;
                  end else
`endif
                  if (we_i) begin
                     state     <= WR_REQ;
                     awvalid_q <= 1'b1;
                     wvalid_q  <= 1'b1;
                  end else begin
                     state     <= RD_REQ;
                     arvalid_q <= 1'b1;
                  end
               end
            end
            WR_REQ: begin
               if (aw_hs) awvalid_q <= 1'b0;
               if (w_hs)  wvalid_q  <= 1'b0;
               aw_done <= aw_fin;
               w_done  <= w_fin;
               if (aw_fin && w_fin) begin
                  state    <= WR_RESP;
                  bready_q <= 1'b1;
                  aw_done  <= 1'b0;
                  w_done   <= 1'b0;
               end
            end
            WR_RESP: begin
               if (axi.bvalid) begin
                  state    <= IDLE;
                  bready_q <= 1'b0;
                  rvalid_q <= 1'b1;
                  err_q    <= resp_is_err(axi.bresp);
                  rdata_q  <= '0;
               end
            end
            RD_REQ: begin
               if (axi.arready) begin
                  state     <= RD_RESP;
                  arvalid_q <= 1'b0;
                  rready_q  <= 1'b1;
               end
            end
            RD_RESP: begin
               if (axi.rvalid) begin
                  state    <= IDLE;
                  rready_q <= 1'b0;
                  rvalid_q <= 1'b1;
                  err_q    <= resp_is_err(axi.rresp);
                  rdata_q  <= axi.rdata;
               end
            end
`ifdef AXI4L_MASTER_ALIGN_CHECK_EN
            ALIGN_ERR: begin
               state    <= IDLE;
               rvalid_q <= 1'b1;
               err_q    <= 1'b1;
               rdata_q  <= '0;
            end
`endif
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_axi4l_master_bridge.sv
// tb/tb_axi4l_master_bridge.sv - self-checking bench for axi4l_master_bridge
// Purpose: memory-backed AXI4-Lite slave with programmable ready/response
//          latencies, a word-array reference model of the core-visible
//          behaviour, directed scenarios and randomized traffic.
// Ports: none (top-level bench). Honours AXI4L_MASTER_ALIGN_CHECK_EN.
module tb_axi4l_master_bridge;
   import axi4l_pkg::*;

   logic        aclk;
   logic        aresetn;
   logic        req_i;
   logic        gnt_o;
   logic        we_i;
   logic [3:0]  be_i;
   logic [31:0] addr_i;
   logic [31:0] wdata_i;
   logic        rvalid_o;
   logic [31:0] rdata_o;
   logic        err_o;

   axi4l_if axi ();

   axi4l_master_bridge #(.PROT(3'b000)) dut (
      .aclk     (aclk),
      .aresetn  (aresetn),
      .req_i    (req_i),
      .gnt_o    (gnt_o),
      .we_i     (we_i),
      .be_i     (be_i),
      .addr_i   (addr_i),
      .wdata_i  (wdata_i),
      .rvalid_o (rvalid_o),
      .rdata_o  (rdata_o),
      .err_o    (err_o),
      .axi      (axi)
   );

   initial aclk = 1'b0;
   always #5 aclk = ~aclk;

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // ---------------- reference model ----------------
   typedef struct {
      logic        err;
      logic [31:0] rdata;
   } exp_t;

   exp_t        exp_q[$];
   logic [31:0] exp_addr_q[$];
   logic [31:0] model_mem [64];

   // ---------------- AXI slave ----------------
   // Address bit 15 selects an error region: SLVERR, reads return 0x12345678,
   // writes do not update memory.
   logic [31:0] slave_mem [64];
   int aw_lat = 0, w_lat = 0, ar_lat = 0, b_lat = 0, r_lat = 0;
   int aw_wait, w_wait, ar_wait, b_wait, r_wait;
   logic        have_aw, have_w, b_pend, r_pend;
   logic [31:0] cap_awaddr, cap_wdata;
   logic [3:0]  cap_wstrb;
   resp_t       b_resp_r, r_resp_r;
   logic [31:0] r_data_r;
   logic        addr_seen;
   logic [31:0] seen_addr;
   logic [2:0]  seen_prot;

   logic        aw_hs, w_hs, ar_hs;
   logic [31:0] wr_addr, wr_data;
   logic [3:0]  wr_strb;

   assign axi.awready = (aw_wait >= aw_lat);
   assign axi.wready  = (w_wait >= w_lat);
   assign axi.arready = (ar_wait >= ar_lat);
   assign axi.bvalid  = b_pend && (b_wait >= b_lat);
   assign axi.bresp   = b_resp_r;
   assign axi.rvalid  = r_pend && (r_wait >= r_lat);
   assign axi.rresp   = r_resp_r;
   assign axi.rdata   = r_data_r;

   assign aw_hs   = axi.awvalid & axi.awready;
   assign w_hs    = axi.wvalid & axi.wready;
   assign ar_hs   = axi.arvalid & axi.arready;
   assign wr_addr = aw_hs ? axi.awaddr : cap_awaddr;
   assign wr_data = w_hs ? axi.wdata : cap_wdata;
   assign wr_strb = w_hs ? axi.wstrb : cap_wstrb;

   always @(posedge aclk) begin
      if (!aresetn) begin
         aw_wait <= 0; w_wait <= 0; ar_wait <= 0; b_wait <= 0; r_wait <= 0;
         have_aw <= 1'b0; have_w <= 1'b0; b_pend <= 1'b0; r_pend <= 1'b0;
         cap_awaddr <= '0; cap_wdata <= '0; cap_wstrb <= '0;
         b_resp_r <= OKAY; r_resp_r <= OKAY; r_data_r <= '0;
         addr_seen <= 1'b0; seen_addr <= '0; seen_prot <= '0;
         for (int i = 0; i < 64; i++) slave_mem[i] <= '0;
      end else begin
         addr_seen <= aw_hs | ar_hs;
         if (aw_hs) begin
            seen_addr <= axi.awaddr; seen_prot <= axi.awprot;
         end else if (ar_hs) begin
            seen_addr <= axi.araddr; seen_prot <= axi.arprot;
         end

         if (aw_hs) begin
            have_aw <= 1'b1; cap_awaddr <= axi.awaddr; aw_wait <= 0;
         end else if (axi.awvalid) aw_wait <= aw_wait + 1;
         if (w_hs) begin
            have_w <= 1'b1; cap_wdata <= axi.wdata; cap_wstrb <= axi.wstrb; w_wait <= 0;
         end else if (axi.wvalid) w_wait <= w_wait + 1;

         if ((have_aw | aw_hs) && (have_w | w_hs) && !b_pend) begin
            if (!wr_addr[15]) begin
               for (int k = 0; k < 4; k++)
                  if (wr_strb[k]) slave_mem[wr_addr[7:2]][8*k +: 8] <= wr_data[8*k +: 8];
            end
            b_pend   <= 1'b1;
            b_wait   <= 0;
            b_resp_r <= wr_addr[15] ? SLVERR : OKAY;
            have_aw  <= 1'b0;
            have_w   <= 1'b0;
         end
         if (b_pend && !axi.bvalid) b_wait <= b_wait + 1;
         if (axi.bvalid && axi.bready) b_pend <= 1'b0;

         if (ar_hs) begin
            r_pend   <= 1'b1;
            r_wait   <= 0;
            ar_wait  <= 0;
            r_resp_r <= axi.araddr[15] ? SLVERR : OKAY;
            r_data_r <= axi.araddr[15] ? 32'h12345678 : slave_mem[axi.araddr[7:2]];
         end else if (axi.arvalid) ar_wait <= ar_wait + 1;
         if (r_pend && !axi.rvalid) r_wait <= r_wait + 1;
         if (axi.rvalid && axi.rready) r_pend <= 1'b0;
      end
   end

   // ---------------- monitor (opposite edge) ----------------
   logic        prev_live;
   logic        prev_awvalid, prev_awready, prev_wvalid, prev_wready, prev_arvalid, prev_arready;
   logic [31:0] prev_awaddr, prev_wdata, prev_araddr;

   always @(negedge aclk) begin
      if (aresetn && prev_live) begin
         if (rvalid_o) begin
            if (exp_q.size() == 0) check("rsp_unexpected", 1'b1, 1'b0);
            else begin
               check("rsp_err", err_o, exp_q[0].err);
               check("rsp_rdata", rdata_o, exp_q[0].rdata);
               void'(exp_q.pop_front());
            end
         end
         if (addr_seen) begin
            if (exp_addr_q.size() == 0) check("axi_addr_unexpected", 1'b1, 1'b0);
            else begin
               check("axi_addr", seen_addr, exp_addr_q[0]);
               check("axi_prot", seen_prot, 3'b000);
               void'(exp_addr_q.pop_front());
            end
         end
         if (gnt_o)
            check("idle_quiet", {axi.awvalid, axi.wvalid, axi.arvalid, axi.bready, axi.rready}, 5'b0);
         if (prev_awvalid && !prev_awready) check("aw_hold", {axi.awvalid, axi.awaddr}, {1'b1, prev_awaddr});
         if (prev_awvalid && prev_awready)  check("aw_drop", axi.awvalid, 1'b0);
         if (prev_wvalid && !prev_wready)   check("w_hold", {axi.wvalid, axi.wdata}, {1'b1, prev_wdata});
         if (prev_wvalid && prev_wready)    check("w_drop", axi.wvalid, 1'b0);
         if (prev_arvalid && !prev_arready) check("ar_hold", {axi.arvalid, axi.araddr}, {1'b1, prev_araddr});
         if (prev_arvalid && prev_arready)  check("ar_drop", axi.arvalid, 1'b0);
         if (axi.arvalid || axi.rready)     check("rd_no_wvalid", axi.wvalid, 1'b0);
      end
      prev_live    <= aresetn;
      prev_awvalid <= axi.awvalid; prev_awready <= axi.awready; prev_awaddr <= axi.awaddr;
      prev_wvalid  <= axi.wvalid;  prev_wready  <= axi.wready;  prev_wdata  <= axi.wdata;
      prev_arvalid <= axi.arvalid; prev_arready <= axi.arready; prev_araddr <= axi.araddr;
   end

   // ---------------- driver helpers ----------------
   task automatic set_lat(input int aw, input int w, input int ar, input int b, input int r);
      aw_lat = aw; w_lat = w; ar_lat = ar; b_lat = b; r_lat = r;
   endtask

   // Called at a negedge; returns at the negedge one cycle after the grant.
   task automatic issue(input logic we, input logic [3:0] be, input logic [31:0] addr,
                        input logic [31:0] wd);
      int   guard;
      logic local_err;
      exp_t e;
      guard = 0;
      req_i = 1'b1; we_i = we; be_i = be; addr_i = addr; wdata_i = wd;
      while (!gnt_o && guard < 200) begin
         @(negedge aclk);
         guard++;
      end
      check("grant", gnt_o, 1'b1);
      if (gnt_o) begin
         local_err = 1'b0;
`ifdef AXI4L_MASTER_ALIGN_CHECK_EN
         local_err = (addr[1:0] != 2'b00);
`endif
         if (local_err) begin
            e.err = 1'b1; e.rdata = '0;
         end else begin
            exp_addr_q.push_back(addr);
            if (addr[15]) begin
               e.err = 1'b1; e.rdata = we ? 32'h0 : 32'h12345678;
            end else if (we) begin
               for (int k = 0; k < 4; k++)
                  if (be[k]) model_mem[addr[7:2]][8*k +: 8] = wd[8*k +: 8];
               e.err = 1'b0; e.rdata = '0;
            end else begin
               e.err = 1'b0; e.rdata = model_mem[addr[7:2]];
            end
         end
         exp_q.push_back(e);
      end
      @(negedge aclk);
      req_i = 1'b0; we_i = 1'b0;
   endtask

   task automatic wait_drain();
      int guard;
      guard = 0;
      while (exp_q.size() != 0 && guard < 300) begin
         @(negedge aclk);
         guard++;
      end
      check("drain_timeout", exp_q.size(), 0);
      @(negedge aclk);
   endtask

   task automatic apply_reset();
      aresetn = 1'b0;
      exp_q.delete();
      exp_addr_q.delete();
      for (int i = 0; i < 64; i++) model_mem[i] = '0;
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int          n, wv_cycles, guard;
      logic        we;
      logic [3:0]  be;
      logic [31:0] addr, wd;

      req_i = 1'b0; we_i = 1'b0; be_i = '0; addr_i = '0; wdata_i = '0;
      apply_reset();
      repeat (3) @(negedge aclk);
      aresetn = 1'b1;
      @(negedge aclk);
      check("rst_gnt", gnt_o, 1'b1);
      check("rst_rsp", {rvalid_o, err_o, rdata_o}, 34'h0);
      check("rst_bus", {axi.awvalid, axi.wvalid, axi.arvalid, axi.bready, axi.rready}, 5'b0);

      // Zero-wait write: AW/W in cycle 1, bready cycle 2, rvalid_o cycle 3.
      set_lat(0, 0, 0, 0, 0);
      issue(1'b1, 4'hF, 32'h4, 32'hDEADBEEF);
      check("wr_c1_awvalid_wvalid", {axi.awvalid, axi.wvalid}, 2'b11);
      @(negedge aclk);
      check("wr_c2_bready", axi.bready, 1'b1);
      @(negedge aclk);
      check("wr_c3_rvalid", rvalid_o, 1'b1);
      wait_drain();

      // Read back, then zero-wait read latency.
      issue(1'b0, 4'h0, 32'h4, 32'h0);
      check("rd_c1_arvalid", axi.arvalid, 1'b1);
      @(negedge aclk);
      check("rd_c2_rready", axi.rready, 1'b1);
      @(negedge aclk);
      check("rd_c3_rvalid", rvalid_o, 1'b1);
      wait_drain();

      // AW delayed 3 cycles, W immediate.
      set_lat(3, 0, 0, 0, 0);
      issue(1'b1, 4'h3, 32'h10, 32'hA5A5_1234);
      n = 0; wv_cycles = 0;
      while (axi.awvalid && n < 20) begin
         n++;
         if (axi.wvalid) wv_cycles++;
         @(negedge aclk);
      end
      check("aw_valid_cycles", n, 4);
      check("w_valid_cycles", wv_cycles, 1);
      wait_drain();
      set_lat(0, 0, 0, 0, 0);
      issue(1'b0, 4'h0, 32'h10, 32'h0);
      wait_drain();

      // Slave error on a read.
      issue(1'b0, 4'h0, 32'h8000, 32'h0);
      wait_drain();

      // Misaligned read.
      issue(1'b0, 4'hF, 32'h6, 32'hFFFF_FFFF);
`ifdef AXI4L_MASTER_ALIGN_CHECK_EN
      check("mis_c1_no_arvalid", axi.arvalid, 1'b0);
      @(negedge aclk);
      check("mis_c2_rvalid", {rvalid_o, axi.arvalid}, 2'b10);
`else
      check("mis_c1_arvalid", axi.arvalid, 1'b1);
`endif
      wait_drain();

      // Reset while waiting on a stalled B response.
      set_lat(0, 0, 0, 40, 0);
      issue(1'b1, 4'hF, 32'h20, 32'h1111_2222);
      guard = 0;
      while (!axi.bready && guard < 50) begin
         @(negedge aclk);
         guard++;
      end
      check("bready_seen", axi.bready, 1'b1);
      @(negedge aclk);
      apply_reset();
      @(negedge aclk);
      check("midrst_bus", {axi.awvalid, axi.wvalid, axi.arvalid, axi.bready, axi.rready}, 5'b0);
      check("midrst_rvalid", rvalid_o, 1'b0);
      aresetn = 1'b1;
      set_lat(0, 0, 0, 0, 0);
      @(negedge aclk);
      check("postrst_gnt", {gnt_o, rvalid_o}, 2'b10);
      repeat (3) @(negedge aclk);

      // Randomized traffic, back-to-back where latencies allow.
      for (int i = 0; i < 300; i++) begin
         if ($urandom_range(0, 3) == 0) begin
            wait_drain();
            set_lat($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                    $urandom_range(0, 3), $urandom_range(0, 3));
         end
         we   = 1'($urandom_range(0, 1));
         be   = 4'($urandom);
         wd   = $urandom;
         addr = {16'h0, ($urandom_range(0, 7) == 0), 7'h0, 6'($urandom_range(0, 15)),
                 ($urandom_range(0, 7) == 0) ? 2'($urandom_range(0, 3)) : 2'b00};
         issue(we, be, addr, wd);
      end
      wait_drain();
      check("addr_q_empty", exp_addr_q.size(), 0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL global_timeout got=1 exp=0");
      $fatal(1);
   end

endmodule
